// File: rtl/param_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : param_updown_counter
// Purpose  : Parametrised up/down counter with a programmable modulus
//            (0..MAX_VAL), synchronous load with clamping, and a selectable
//            wrap or saturate boundary mode. It also produces a terminal-count
//            flag, one-cycle overflow/underflow pulses and a sticky error flag.
//            Optional enable prescaler when UDC_PRESCALE_EN is defined.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous active-high reset
//            en         - count enable
//            up_down    - 1 = increment, 0 = decrement
//            mode       - 0 = wrap, 1 = saturate at the boundary
//            load       - synchronous load strobe (has priority over counting)
//            load_val   - load value, clamped to MAX_VAL
//            clr_flags  - clears sticky_err (an ovf/unf event on the same
//                         edge wins)
//            count      - registered count
//            tc         - terminal count, combinational from count/up_down
//            ovf, unf   - registered one-cycle boundary pulses
//            sticky_err - set by any ovf/unf event
// Macro    : UDC_PRESCALE_EN - when defined, a step happens only every
//            PRESCALE enabled cycles
// Revision : 1.0 - initial release
// ============================================================================
module param_updown_counter #(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_down,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             unf,
    output logic             sticky_err
);

    localparam logic [WIDTH-1:0] c_max_val = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] c_zero    = '0;
    localparam logic [WIDTH-1:0] c_one     = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic             r_ovf;
    logic             r_unf;
    logic             r_sticky;

    logic             w_at_max;
    logic             w_at_zero;
    logic             w_presc_tc;
    logic             w_step;
    logic             w_ovf_evt;
    logic             w_unf_evt;
    logic [WIDTH-1:0] w_load_clamped;

    assign w_at_max  = (r_count == c_max_val);
    assign w_at_zero = (r_count == c_zero);

`ifdef UDC_PRESCALE_EN
    // Prescaler runs 0..PRESCALE-1 on enabled, non-load cycles; the step
    // fires on the cycle it sits at PRESCALE-1.
    localparam int c_presc_w = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(PRESCALE - 1);
    localparam logic [c_presc_w-1:0] c_presc_one  = c_presc_w'(1);

    logic [c_presc_w-1:0] r_presc;

    assign w_presc_tc = (r_presc == c_presc_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (load) begin
            r_presc <= '0;
        end else if (en) begin
            r_presc <= w_presc_tc ? '0 : (r_presc + c_presc_one);
        end
    end
`else
    // No prescaler: every enabled cycle is a step. Any legal PRESCALE (>=1)
    // makes this constant 1.
    assign w_presc_tc = (PRESCALE >= 1);
`endif

    assign w_step    = en & ~load & w_presc_tc;
    assign w_ovf_evt = w_step &  up_down & w_at_max;
    assign w_unf_evt = w_step & ~up_down & w_at_zero;

    assign w_load_clamped = (load_val > c_max_val) ? c_max_val : load_val;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_ovf <= w_ovf_evt;
            r_unf <= w_unf_evt;
            if (load) begin
                r_count <= w_load_clamped;
            end else if (w_step) begin
                if (up_down) begin
                    if (w_at_max) begin
                        r_count <= mode ? c_max_val : c_zero;
                    end else begin
                        r_count <= r_count + c_one;
                    end
                end else begin
                    if (w_at_zero) begin
                        r_count <= mode ? c_zero : c_max_val;
                    end else begin
                        r_count <= r_count - c_one;
                    end
                end
            end
        end
    end

    // A boundary event on the same edge as clr_flags keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= 1'b0;
        end else if (w_ovf_evt | w_unf_evt) begin
            r_sticky <= 1'b1;
        end else if (clr_flags) begin
            r_sticky <= 1'b0;
        end
    end

    assign count      = r_count;
    assign ovf        = r_ovf;
    assign unf        = r_unf;
    assign sticky_err = r_sticky;
    assign tc         = up_down ? w_at_max : w_at_zero;

endmodule
`default_nettype wire

// File: tb/tb_param_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_updown_counter
// Purpose  : Self-checking bench for param_updown_counter (WIDTH=4,
//            MAX_VAL=9, PRESCALE=4) with a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_updown_counter;

    localparam int W    = 4;
    localparam int MAXV = 9;
    localparam int PS   = 4;

    logic         clk;
    logic         rst;
    logic         en;
    logic         up_down;
    logic         mode;
    logic         load;
    logic [W-1:0] load_val;
    logic         clr_flags;
    logic [W-1:0] count;
    logic         tc;
    logic         ovf;
    logic         unf;
    logic         sticky_err;

    int tests;
    int fails;

    // Reference model state
    int m_count;
    int m_ovf;
    int m_unf;
    int m_sticky;
`ifdef UDC_PRESCALE_EN
    int m_presc;
`endif

    param_updown_counter #(
        .WIDTH    (W),
        .MAX_VAL  (MAXV),
        .PRESCALE (PS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .up_down    (up_down),
        .mode       (mode),
        .load       (load),
        .load_val   (load_val),
        .clr_flags  (clr_flags),
        .count      (count),
        .tc         (tc),
        .ovf        (ovf),
        .unf        (unf),
        .sticky_err (sticky_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        m_count  = 0;
        m_ovf    = 0;
        m_unf    = 0;
        m_sticky = 0;
`ifdef UDC_PRESCALE_EN
        m_presc  = 0;
`endif
    endfunction

    // One rising edge of the specified behaviour, in plain arithmetic.
    function automatic void model_edge();
        bit step;
        m_ovf = 0;
        m_unf = 0;
        if (load) begin
            m_count = (int'(load_val) > MAXV) ? MAXV : int'(load_val);
`ifdef UDC_PRESCALE_EN
            m_presc = 0;
`endif
            if (clr_flags) m_sticky = 0;
        end else begin
            step = en;
`ifdef UDC_PRESCALE_EN
            step = en && (m_presc == PS - 1);
            if (en) m_presc = (m_presc + 1) % PS;
`endif
            if (step) begin
                if (up_down) begin
                    if (m_count == MAXV) begin
                        m_ovf = 1;
                        if (!mode) m_count = 0;
                    end else begin
                        m_count = m_count + 1;
                    end
                end else begin
                    if (m_count == 0) begin
                        m_unf = 1;
                        if (!mode) m_count = MAXV;
                    end else begin
                        m_count = m_count - 1;
                    end
                end
            end
            if (m_ovf || m_unf) m_sticky = 1;
            else if (clr_flags) m_sticky = 0;
        end
    endfunction

    function automatic int model_tc();
        return up_down ? int'(m_count == MAXV) : int'(m_count == 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        en        = 1'b0;
        up_down   = 1'b1;
        mode      = 1'b0;
        load      = 1'b0;
        load_val  = '0;
        clr_flags = 1'b0;
    endtask

    task automatic do_load(input int v);
        load     = 1'b1;
        load_val = W'(v);
        tick();
        load     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (count !== 4'd0 || ovf !== 1'b0 || unf !== 1'b0 || sticky_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got count=%0d ovf=%b unf=%b sticky=%b, want 0 0 0 0",
                     count, ovf, unf, sticky_err);
        end
        rst = 1'b0;
        do_load(5);
        tests++;
        if (count !== 4'd5) begin
            fails++;
            $display("FAIL reset_preload: got count=%0d, want 5", count);
        end
        // Assert reset between edges; it must act before the next edge.
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        tests++;
        if (count !== 4'd0 || ovf !== 1'b0 || unf !== 1'b0 || sticky_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: got count=%0d ovf=%b unf=%b sticky=%b, want 0 0 0 0",
                     count, ovf, unf, sticky_err);
        end
        en = 1'b1;
        load = 1'b1;
        load_val = 4'd7;
        repeat (2) tick();
        tests++;
        if (count !== 4'd0 || sticky_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: got count=%0d sticky=%b, want 0 0", count, sticky_err);
        end
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_wrap_up();
        int exp_c;
        do_load(0);
        mode    = 1'b0;
        up_down = 1'b1;
        en      = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            tests++;
            if (count !== W'(m_count) || ovf !== m_ovf[0] || tc !== model_tc()[0]) begin
                fails++;
                $display("FAIL wrap_up[%0d]: got count=%0d ovf=%b tc=%b, want %0d %0d %0d",
                         i, count, ovf, tc, m_count, m_ovf, model_tc());
            end
`ifndef UDC_PRESCALE_EN
            exp_c = (i + 1) % 10;
            tests++;
            if (count !== W'(exp_c) || ovf !== (i == 9) || tc !== (exp_c == 9)) begin
                fails++;
                $display("FAIL wrap_up_seq[%0d]: got count=%0d ovf=%b tc=%b, want %0d %b %b",
                         i, count, ovf, tc, exp_c, (i == 9), (exp_c == 9));
            end
`endif
        end
        en = 1'b0;
        tick();
        tests++;
        if (sticky_err !== m_sticky[0]) begin
            fails++;
            $display("FAIL wrap_sticky: got %b, want %0d", sticky_err, m_sticky);
        end
    endtask

    task automatic test_sat_down();
        int exp_cnt [4];
        int exp_unf [4];
        exp_cnt = '{1, 0, 0, 0};
        exp_unf = '{0, 0, 1, 1};
        do_load(2);
        mode    = 1'b1;
        up_down = 1'b0;
        en      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (count !== W'(m_count) || unf !== m_unf[0]) begin
                fails++;
                $display("FAIL sat_down[%0d]: got count=%0d unf=%b, want %0d %0d",
                         i, count, unf, m_count, m_unf);
            end
`ifndef UDC_PRESCALE_EN
            tests++;
            if (count !== W'(exp_cnt[i]) || unf !== exp_unf[i][0]) begin
                fails++;
                $display("FAIL sat_down_seq[%0d]: got count=%0d unf=%b, want %0d %0d",
                         i, count, unf, exp_cnt[i], exp_unf[i]);
            end
`endif
        end
        en        = 1'b0;
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        tests++;
        if (sticky_err !== 1'b0 || unf !== 1'b0) begin
            fails++;
            $display("FAIL sat_clr: got sticky=%b unf=%b, want 0 0", sticky_err, unf);
        end
    endtask

    task automatic test_load_clamp();
        en       = 1'b1;
        up_down  = 1'b1;
        mode     = 1'b0;
        do_load(15);
        en = 1'b0;
        tests++;
        if (count !== 4'd9 || ovf !== 1'b0 || count !== W'(m_count)) begin
            fails++;
            $display("FAIL load_clamp: got count=%0d ovf=%b, want 9 0", count, ovf);
        end
    endtask

    task automatic test_sat_clr_same_edge();
        mode    = 1'b1;
        up_down = 1'b1;
        en      = 1'b1;
        tick();
        clr_flags = 1'b1;
        tick();
        tests++;
        if (count !== W'(m_count) || ovf !== m_ovf[0] || sticky_err !== m_sticky[0]) begin
            fails++;
            $display("FAIL sat_clr_edge: got count=%0d ovf=%b sticky=%b, want %0d %0d %0d",
                     count, ovf, sticky_err, m_count, m_ovf, m_sticky);
        end
`ifndef UDC_PRESCALE_EN
        tests++;
        if (count !== 4'd9 || ovf !== 1'b1 || sticky_err !== 1'b1) begin
            fails++;
            $display("FAIL sat_clr_edge_const: got count=%0d ovf=%b sticky=%b, want 9 1 1",
                     count, ovf, sticky_err);
        end
`endif
        idle_inputs();
        tick();
    endtask

`ifdef UDC_PRESCALE_EN
    task automatic test_prescale();
        do_load(0);
        up_down = 1'b1;
        mode    = 1'b0;
        en      = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            tests++;
            if (count !== W'(i / PS)) begin
                fails++;
                $display("FAIL prescale[%0d]: got count=%0d, want %0d", i, count, i / PS);
            end
        end
        idle_inputs();
        tick();
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en        = ($urandom_range(0, 3) != 0);
            up_down   = $urandom_range(0, 1) != 0;
            mode      = $urandom_range(0, 1) != 0;
            load      = ($urandom_range(0, 9) == 0);
            load_val  = W'($urandom_range(0, 15));
            clr_flags = ($urandom_range(0, 7) == 0);
            #1;
            tests++;
            if (tc !== model_tc()[0]) begin
                fails++;
                $display("FAIL random_tc[%0d]: got %b, want %0d", i, tc, model_tc());
            end
            tick();
            tests++;
            if (count !== W'(m_count) || ovf !== m_ovf[0] || unf !== m_unf[0] ||
                sticky_err !== m_sticky[0]) begin
                fails++;
                $display("FAIL random[%0d]: got count=%0d ovf=%b unf=%b sticky=%b, want %0d %0d %0d %0d",
                         i, count, ovf, unf, sticky_err, m_count, m_ovf, m_unf, m_sticky);
            end
        end
        idle_inputs();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_load_clamp();
        test_sat_clr_same_edge();
`ifdef UDC_PRESCALE_EN
        test_prescale();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
Parametrised up/down counter with a programmable modulus, synchronous load, and a selectable wrap or saturate mode. It also produces a terminal-count flag, one-cycle overflow/underflow pulses and a sticky error flag. It is the general-purpose successor to the fixed-width up/down counter and serves as the timer/event-counter primitive for upcoming blocks. Single clock domain.

Parameters:
WIDTH, 8, counter width in bits (>=2).
MAX_VAL, 2**WIDTH-1, top count value; the count range is 0..MAX_VAL. Legal range is 1 <= MAX_VAL <= 2**WIDTH-1.
PRESCALE, 4, enable divider ratio (>=1). Used only when UDC_PRESCALE_EN is defined.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
en  input  1  count enable.
up_down  input  1  direction: 1 = increment, 0 = decrement.
mode  input  1  boundary mode: 0 = wrap, 1 = saturate.
load  input  1  synchronous load strobe.
load_val  input  WIDTH  load value.
clr_flags  input  1  clears sticky_err.
count  output  WIDTH  current count, registered.
tc  output  1  terminal count, combinational from count and up_down.
ovf  output  1  overflow pulse, registered.
unf  output  1  underflow pulse, registered.
sticky_err  output  1  set by any ovf or unf event.

Behaviour:
- Reset: rst=1 asynchronously forces count=0, ovf=0, unf=0, sticky_err=0 and the prescaler to 0. These hold for as long as rst=1. Asserting rst mid-operation aborts any pending load or step.
- Per-edge priority: load > counting step > hold.
- Load:
  - When load=1, count <= min(load_val, MAX_VAL); the clamp applies when load_val > MAX_VAL.
  - ovf and unf are 0 on the following cycle; en is ignored that cycle.
  - The prescaler is cleared to 0.
- Step: occurs when load=0 and en=1 (and the prescaler terminal condition holds when UDC_PRESCALE_EN is defined).
  - up_down=1, count<MAX_VAL: count+1.
  - up_down=1, count==MAX_VAL: wrap mode -> 0; saturate mode -> hold MAX_VAL. ovf=1 for exactly the next cycle in both modes.
  - up_down=0, count>0: count-1.
  - up_down=0, count==0: wrap mode -> MAX_VAL; saturate mode -> hold 0. unf=1 for exactly the next cycle in both modes.
- Counting latency: one cycle from an en sample to the updated count.
- ovf/unf: 0 on any cycle without a boundary step. Held at 1 on consecutive cycles when the boundary is hit repeatedly (saturate mode, en held).
- tc: 1 when (up_down=1 and count==MAX_VAL) or (up_down=0 and count==0), regardless of en.
- sticky_err:
  - Set on the same edge that sets ovf or unf.
  - clr_flags=1 clears it on the next edge, unless an ovf/unf event occurs on that same edge; set wins.
- Arithmetic: all comparisons use WIDTH bits. There is no intermediate value above MAX_VAL, so the counter never passes through 2**WIDTH.
- Changing up_down or mode takes effect on the next step; no pipeline state is involved.

Optional Feature:
- Macro: UDC_PRESCALE_EN.
- Defined:
  - An internal prescaler 0..PRESCALE-1 advances on each cycle with en=1 and load=0.
  - A counting step occurs only on the cycle where the prescaler equals PRESCALE-1 and en=1; the prescaler then returns to 0.
  - With en=0 the prescaler holds.
  - PRESCALE=1 behaves identically to the macro-undefined build.
- Undefined: no prescaler logic; every en=1 cycle is a step and PRESCALE is ignored.

Test Plan:
- rst asserted between clock edges with count=5 -> count=0, ovf=unf=sticky_err=0 before the next edge; held while rst=1.
- WIDTH=4, MAX_VAL=9, mode=0, up_down=1, en=1 for 12 cycles from 0 -> count 1..9,0,1,2; ovf=1 only in the cycle count shows 0; tc=1 while count=9; sticky_err=1 afterwards.
- MAX_VAL=9, load_val=2 with load, then mode=1, up_down=0, en=1 for 4 cycles -> count 1,0,0,0; unf=1 in the last two cycles; then clr_flags=1 with en=0 -> sticky_err=0.
- load=1, load_val=15, en=1, MAX_VAL=9 -> count=9 next cycle, ovf=0 (load wins and clamps).
- count=9, mode=1, up_down=1, en=1, clr_flags=1 on the same edge -> count stays 9, ovf=1, sticky_err remains 1.
- UDC_PRESCALE_EN defined, PRESCALE=4, up_down=1, en=1 for 12 cycles from 0 -> count increments on cycles 4, 8 and 12 only (final count 3); en=0 for 2 cycles mid-sequence delays each subsequent step by 2 cycles.
